test_i12605: RTL and testbench

Small clocked control-logic block: five single-bit inputs feed a 3-bit internal state register and a Mealy-style single-bit output. It is a gate-level benchmark kernel for the team's exhaustive-sweep characterisation flow. Each input vector is applied and the output is logged, so the block must be fully deterministic from reset.

---
 rtl/test_i12605.sv | 35 +++
 tb/tb_test_i12605.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/test_i12605.sv
// test_i12605: five-input clocked control kernel with a 3-bit state.
// Ports: N0..N4 data in, CK clock, reset async active-high, Q Mealy out.
module test_i12605 (
  input  logic N0,
  input  logic N1,
  input  logic N2,
  input  logic N3,
  input  logic N4,
  input  logic CK,
  input  logic reset,
  output logic Q
);

  // s_q[0] = S0, s_q[1] = S1, s_q[2] = S2
  logic [2:0] s_q;
  logic [2:0] s_d;
  logic       g;

  always_comb begin
    g      = (N0 & N1) | (N2 ^ N3);
    s_d[0] = g ^ s_q[1];
    s_d[1] = N4 & ~s_q[0];
    s_d[2] = s_q[0] | (N0 & ~N2);
  end

  always_ff @(posedge CK or posedge reset) begin
    if (reset) s_q <= 3'b000;
    else       s_q <= s_d;
  end

  // With the state cleared this reduces to N1 & N3, so reset needs
  // no separate output path.
  assign Q = (s_q[2] & ~N4) ^ (s_q[1] | (N1 & N3));

endmodule

// File: tb/tb_test_i12605.sv
// tb_test_i12605: scoreboard bench for test_i12605.
// Driver queues expected Q values; a monitor pops and compares them.
module tb_test_i12605;

  logic N0, N1, N2, N3, N4;
  logic CK;
  logic reset;
  logic Q;

  test_i12605 dut (
    .N0(N0), .N1(N1), .N2(N2), .N3(N3), .N4(N4),
    .CK(CK), .reset(reset), .Q(Q)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  typedef struct {
    string name;
    logic  exp;
  } chk_t;

  chk_t exp_q[$];
  event chk_ev;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model of the equations (S0 S1 S2 held as m_s[0..2])
  logic [2:0] m_s;

  function automatic logic [2:0] ref_next(input logic [2:0] s,
                                          input logic [4:0] v);
    logic n0, n1, n2, n3, n4, gg;
    logic [2:0] r;
    {n0, n1, n2, n3, n4} = v;
    gg   = (n0 & n1) | (n2 ^ n3);
    r[0] = gg ^ s[1];
    r[1] = n4 & ~s[0];
    r[2] = s[0] | (n0 & ~n2);
    return r;
  endfunction

  function automatic logic ref_q(input logic [2:0] s,
                                 input logic [4:0] v);
    logic n1, n3, n4;
    n1 = v[3];
    n3 = v[1];
    n4 = v[0];
    return (s[2] & ~n4) ^ (s[1] | (n1 & n3));
  endfunction

  always @(posedge CK or posedge reset) begin
    if (reset) m_s <= 3'b000;
    else       m_s <= ref_next(m_s, {N0, N1, N2, N3, N4});
  end

  task automatic set_n(input logic [4:0] v);
    {N0, N1, N2, N3, N4} = v;
  endtask

  task automatic expect_q(input string name, input logic e);
    chk_t c;
    c.name = name;
    c.exp  = e;
    exp_q.push_back(c);
    -> chk_ev;
  endtask

  // Monitor: compares Q whenever the driver announces a sample point
  initial begin
    chk_t c;
    forever begin
      @(chk_ev);
      while (exp_q.size() > 0) begin
        c = exp_q.pop_front();
        n_cmp++;
        if (Q !== c.exp) begin
          n_bad++;
          $display("FAIL %s: Q=%b expected=%b at t=%0t",
                   c.name, Q, c.exp, $time);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #20000;
    $display("FAIL watchdog: timeout at t=%0t", $time);
    $fatal(1);
  end

  logic walk_exp [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    reset = 1'b1;
    set_n(5'b00000);

    // Reset check
    #2 expect_q("rst_zero", 1'b0);
    #1 set_n(5'b01010);
    #1 expect_q("rst_n1n3", 1'b1);
    repeat (3) begin
      @(posedge CK);
      #2 expect_q("rst_clk", 1'b1);
    end

    // Single-edge load
    @(negedge CK);
    reset = 1'b0;
    set_n(5'b11000);
    #1 expect_q("load_pre", 1'b0);
    @(posedge CK);
    #2 set_n(5'b00000);
    #1 expect_q("load_q", 1'b1);

    // Async reset between edges
    #1 reset = 1'b1;
    #1 expect_q("async_q", 1'b0);
    @(negedge CK);
    reset = 1'b0;
    #1 expect_q("release_q", 1'b0);

    // Sequence walk from the cleared state
    set_n(5'b00001);
    #1 expect_q("walk_pre", 1'b0);
    @(posedge CK);
    #2 set_n(5'b00000);
    #1 expect_q("walk1", walk_exp[0]);
    for (int k = 1; k < 4; k++) begin
      @(posedge CK);
      #2 expect_q($sformatf("walk%0d", k + 1), walk_exp[k]);
    end

    // Exhaustive sweep, one vector per half period
    @(posedge CK);
    #2 reset = 1'b1;
    set_n(5'b00000);
    @(negedge CK);
    reset = 1'b0;
    #2;
    for (int v = 0; v < 32; v++) begin
      set_n(v[4:0]);
      #1 expect_q($sformatf("sweep_%05b", v[4:0]),
                  ref_q(m_s, v[4:0]));
      #4;
    end

    #2;
    if (exp_q.size() != 0) begin
      n_bad += exp_q.size();
      $display("FAIL drain: %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
